// File: rtl/hif_fir_reader.sv
// Read sequencer and MAC engine for the high-frequency sample queue: walks a
// TAPS-long window from the oldest pointer and emits one saturated filtered sample.
module hif_fir_reader #(
    parameter int DEPTH = 1536,
    parameter int TAPS  = 1021,
    parameter int AW    = 11,
    parameter int CW    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wrt_smpl,
    input  logic                 queue_full,
    input  logic [AW-1:0]        oldest_ptr,
    output logic [AW-1:0]        raddr,
    input  logic signed [15:0]   rdata,
    output logic [CW-1:0]        coeff_addr,
    input  logic signed [15:0]   coeff,
    output logic [15:0]          smpl_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int                 CNTW      = $clog2(TAPS + 1);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CNTW-1:0]    LAST_CNT  = CNTW'(TAPS - 1);
    localparam logic signed [41:0] SAT_HI    = 42'sd32767;
    localparam logic signed [41:0] SAT_LO    = -42'sd32768;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [CNTW-1:0]       cnt;
    logic                  pipe_valid;
    logic signed [41:0]    acc;
    logic signed [31:0]    prod;
    logic signed [41:0]    acc_next;
    logic signed [41:0]    scaled;
    logic [15:0]           sat_val;

    // Data returns one cycle after issue, so pipe_valid qualifies the product
    // and the DRAIN-cycle result is folded in before it is registered.
    always_comb begin
        prod     = rdata * coeff;
        acc_next = pipe_valid ? (acc + $signed({{10{prod[31]}}, prod})) : acc;
        scaled   = acc_next >>> 15;
        if (scaled > SAT_HI)
            sat_val = 16'h7FFF;
        else if (scaled < SAT_LO)
            sat_val = 16'h8000;
        else
            sat_val = scaled[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            raddr      <= '0;
            coeff_addr <= '0;
            smpl_out   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= (state == RUN);
            acc        <= acc_next;
            valid      <= 1'b0;
            if (wrt_smpl && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (wrt_smpl && queue_full) begin
                        raddr      <= oldest_ptr;
                        coeff_addr <= '0;
                        acc        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    raddr      <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
                    coeff_addr <= coeff_addr + 1'b1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= DRAIN;
                end
                DRAIN: begin
                    smpl_out <= sat_val;
                    valid    <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hif_fir_reader.sv
// Self-checking bench for hif_fir_reader with a small queue (DEPTH=8, TAPS=4),
// synchronous RAM/ROM models and a plain-arithmetic reference filter.
module tb_hif_fir_reader;

    localparam int DEPTH = 8;
    localparam int TAPS  = 4;
    localparam int AW    = 3;
    localparam int CW    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wrt_smpl;
    logic                queue_full;
    logic [AW-1:0]       oldest_ptr;
    logic [AW-1:0]       raddr;
    logic signed [15:0]  rdata;
    logic [CW-1:0]       coeff_addr;
    logic signed [15:0]  coeff;
    logic [15:0]         smpl_out;
    logic                valid;
    logic                busy;
    logic                overrun;

    logic signed [15:0]  mem [DEPTH];
    logic signed [15:0]  coef [TAPS];
    int                  checks = 0;
    int                  errors = 0;
    logic                overrun_exp = 1'b0;

    hif_fir_reader #(.DEPTH(DEPTH), .TAPS(TAPS), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .queue_full(queue_full),
        .oldest_ptr(oldest_ptr), .raddr(raddr), .rdata(rdata),
        .coeff_addr(coeff_addr), .coeff(coeff), .smpl_out(smpl_out),
        .valid(valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Queue RAM and coefficient ROM both return data one cycle after the address.
    always @(posedge clk) begin
        rdata <= mem[raddr];
        coeff <= coef[coeff_addr];
    end

    function automatic logic [15:0] refFilter(input int ptr);
        longint sum = 0;
        for (int i = 0; i < TAPS; i++)
            sum += longint'(mem[(ptr + i) % DEPTH]) * longint'(coef[i]);
        sum = sum >>> 15;
        if (sum > 32767)  return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
        return sum[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic full);
        @(negedge clk);
        queue_full = full;
        wrt_smpl   = 1'b1;
        @(negedge clk);
        wrt_smpl   = 1'b0;
    endtask

    task automatic loadConst(input logic [15:0] word, input logic [15:0] c);
        for (int i = 0; i < DEPTH; i++) mem[i] = word;
        for (int i = 0; i < TAPS; i++)  coef[i] = c;
    endtask

    // Cycle k counts from the first RUN cycle after the accepted pulse.
    task automatic runWindow(input int ptr, input int extra, input logic [15:0] exp, input logic move_ptr);
        oldest_ptr = AW'(ptr);
        applyStimulus(1'b1);
        if (move_ptr) oldest_ptr = AW'($urandom_range(DEPTH - 1));
        for (int k = 1; k <= TAPS + 3; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= TAPS) begin
                checkOutput("raddr", 32'(raddr), 32'((ptr + k - 1) % DEPTH));
                checkOutput("coeff_addr", 32'(coeff_addr), 32'(k - 1));
            end
            checkOutput("valid", 32'(valid), 32'(k == TAPS + 2));
            checkOutput("busy", 32'(busy), 32'(k <= TAPS + 2));
            if (k >= TAPS + 2) checkOutput("smpl_out", 32'(smpl_out), 32'(exp));
            wrt_smpl = (extra != 0 && k == extra);
            if (wrt_smpl) overrun_exp = 1'b1;
        end
        wrt_smpl = 1'b0;
        checkOutput("overrun", 32'(overrun), 32'(overrun_exp));
    endtask

    initial begin
        rst_n      = 1'b0;
        wrt_smpl   = 1'b0;
        queue_full = 1'b0;
        oldest_ptr = '0;
        loadConst(16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("reset_raddr", 32'(raddr), 0);
        checkOutput("reset_coeff_addr", 32'(coeff_addr), 0);
        checkOutput("reset_smpl_out", 32'(smpl_out), 0);
        checkOutput("reset_valid", 32'(valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        rst_n = 1'b1;

        // Unprimed queue: the pulse must be ignored entirely.
        oldest_ptr = 3'd5;
        applyStimulus(1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("unprimed_busy", 32'(busy), 0);
            checkOutput("unprimed_valid", 32'(valid), 0);
            checkOutput("unprimed_raddr", 32'(raddr), 0);
            checkOutput("unprimed_overrun", 32'(overrun), 0);
            @(negedge clk);
        end

        loadConst(16'h4000, 16'h2000);
        runWindow(0, 0, 16'h4000, 1'b0);

        loadConst(16'h0000, 16'h7FFF);
        mem[6] = 16'sd1; mem[7] = 16'sd2; mem[0] = 16'sd3; mem[1] = 16'sd4;
        mem[2] = 16'sd1000; mem[5] = -16'sd1000;
        runWindow(6, 0, 16'h0009, 1'b1);

        loadConst(16'h8000, 16'h7FFF);
        runWindow(3, 0, 16'h8000, 1'b0);
        loadConst(16'h7FFF, 16'h7FFF);
        runWindow(1, 0, 16'h7FFF, 1'b0);

        for (int w = 0; w < 8; w++) begin
            int ptr;
            for (int i = 0; i < DEPTH; i++)
                mem[i] = (w % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
            for (int i = 0; i < TAPS; i++)
                coef[i] = (w % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 8191)) - 4096);
            ptr = int'($urandom_range(DEPTH - 1));
            runWindow(ptr, 0, refFilter(ptr), 1'b1);
        end

        loadConst(16'h4000, 16'h2000);
        runWindow(0, 2, 16'h4000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("overrun_sticky", 32'(overrun), 1);
        checkOutput("overrun_no_extra_valid", 32'(valid), 0);

        // Reset in the middle of RUN aborts the window without a valid pulse.
        oldest_ptr = 3'd2;
        applyStimulus(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_raddr", 32'(raddr), 0);
        checkOutput("abort_coeff_addr", 32'(coeff_addr), 0);
        checkOutput("abort_smpl_out", 32'(smpl_out), 0);
        checkOutput("abort_valid", 32'(valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_overrun", 32'(overrun), 0);
        overrun_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < TAPS + 3; k++) begin
            @(negedge clk);
            checkOutput("abort_no_valid", 32'(valid), 0);
            checkOutput("abort_idle_busy", 32'(busy), 0);
        end
        runWindow(0, 0, 16'h4000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
